// File: rtl/binomial_decimator.sv
// rtl/binomial_decimator.sv - integrate-and-dump decimator with rounding, saturation and 2-entry output FIFO
//
// Ports:
//   clk        single clock, all state on posedge
//   rst        synchronous active-high reset
//   in_valid   inp carries a sample this cycle
//   inp        unsigned input sample, DW bits
//   out_valid  outp holds a decimated result (registered, independent of out_ready)
//   out_ready  consumer accepts outp this cycle
//   outp       normalised, saturated result at the FIFO head (0 when empty)
//   overflow   sticky: a result was dropped because the FIFO was full
module binomial_decimator #(
    parameter int DW    = 8,
    parameter int DEC   = 4,
    parameter int SHIFT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] inp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] outp,
    output logic          overflow
);

    localparam int AW = DW + $clog2(DEC);
    localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;
    // One spare bit so the rounding add cannot wrap.
    localparam int WW = AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEC - 1);

    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    occ_q, occ_d;
    logic          ovf_q, ovf_d;

    logic [AW-1:0] sum;
    logic [WW-1:0] scaled;
    logic [DW-1:0] result;
    logic          dump;
    logic          pop;
    logic          push;
    logic          full;

    assign sum = acc_q + AW'(inp);

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [WW-1:0] RND = WW'(1) << (SHIFT - 1);
            assign scaled = (WW'(sum) + RND) >> SHIFT;
        end else begin : g_noround
            assign scaled = WW'(sum);
        end
    endgenerate

    // Anything above DW bits clamps to full scale.
    assign result = (|scaled[WW-1:DW]) ? {DW{1'b1}} : scaled[DW-1:0];

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;

        dump = in_valid && (cnt_q == CNT_LAST);
        pop  = (occ_q != 2'd0) && out_ready;
        full = (occ_q == 2'd2);
        // When full, a same-cycle pop frees the slot the write pointer already points at.
        push = dump && (!full || pop);

        if (in_valid) begin
            if (dump) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (dump && full && !pop) begin
            ovf_d = 1'b1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = (occ_q != 2'd0);
    assign outp      = out_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow  = ovf_q;

endmodule
